// File: rtl/bram_sample_reader_if.sv
// Handshake and BRAM read-port bundle between the capture-buffer reader and its neighbours.
// The reader takes the slave view; the host/BRAM side takes the master view.
interface bram_sample_reader_if #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 64,
    parameter int SAMPLE_W = 16
);
    logic                i_start;
    logic [ADDR_W-1:0]   i_base_addr;
    logic [ADDR_W:0]     i_word_count;
    logic [ADDR_W-1:0]   o_rdaddress;
    logic                o_rden;
    logic [DATA_W-1:0]   i_q;
    logic [SAMPLE_W-1:0] o_sample;
    logic                o_valid;
    logic                i_ready;
    logic                o_last;
    logic                o_busy;
    logic                o_done;

    modport master (
        output i_start, i_base_addr, i_word_count, i_q, i_ready,
        input  o_rdaddress, o_rden, o_sample, o_valid, o_last, o_busy, o_done
    );

    modport slave (
        input  i_start, i_base_addr, i_word_count, i_q, i_ready,
        output o_rdaddress, o_rden, o_sample, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/bram_sample_reader.sv
// Reads a span of 64-bit capture words from BRAM and streams them out as 16-bit samples.
// A credit counter bounds reads in flight plus buffered words, so backpressure never overflows.
module bram_sample_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int SAMPLE_W   = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_62clk,
    input  logic                 i_reset,
    bram_sample_reader_if.slave  bus
);
    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   rdaddress;
    logic                rden;
    logic                busy;
    logic                done;
    logic [ADDR_W:0]     issue_left;
    logic [ADDR_W:0]     pop_left;
    logic [RD_LAT-1:0]   vld_p;
    logic [CNT_W-1:0]    used;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [DATA_W-1:0]   hold_word;
    logic [LANE_W-1:0]   lane;
    logic                hold_vld;
    logic                hold_final;

    logic land, hs, at_last_lane, free, final_hs, take, fifo_empty;
    logic load_fifo, load_bypass, fifo_wr, start_ok, issue, grant;

    // Credits cover reads in flight, FIFO words and the word held by the serializer.
    assign land         = vld_p[RD_LAT-1];
    assign hs           = hold_vld & bus.i_ready;
    assign at_last_lane = (lane == LAST_LANE);
    assign free         = hs & at_last_lane;
    assign final_hs     = free & hold_final;
    assign take         = ~hold_vld | free;
    assign fifo_empty   = (fifo_cnt == '0);
    assign load_fifo    = take & ~fifo_empty;
    assign load_bypass  = take & fifo_empty & land;
    assign fifo_wr      = land & ~load_bypass;
    assign start_ok     = (state == IDLE) & bus.i_start;
    assign issue        = (state == RUN) & (issue_left != '0) &
                          ((used < CNT_W'(FIFO_DEPTH)) | free);
    assign grant        = issue | (start_ok & (bus.i_word_count != '0));

    always_ff @(posedge i_62clk) begin
        if (i_reset) begin
            state      <= IDLE;
            rdaddress  <= '0;
            rden       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            issue_left <= '0;
            pop_left   <= '0;
            vld_p      <= '0;
            used       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            lane       <= '0;
            hold_vld   <= 1'b0;
            hold_final <= 1'b0;
        end else begin
            done  <= 1'b0;
            vld_p <= (vld_p << 1) | RD_LAT'(rden);
            used  <= used + CNT_W'(grant) - CNT_W'(free);

            case (state)
                IDLE: begin
                    rden <= 1'b0;
                    if (bus.i_start) begin
                        if (bus.i_word_count != '0) begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            rden       <= 1'b1;
                            rdaddress  <= bus.i_base_addr;
                            issue_left <= bus.i_word_count - 1'b1;
                            pop_left   <= bus.i_word_count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rden <= issue;
                    if (issue) begin
                        rdaddress  <= rdaddress + 1'b1;
                        issue_left <= issue_left - 1'b1;
                    end
                    if (issue_left == '0) state <= DRAIN;
                end
                DRAIN:   rden <= 1'b0;
                default: state <= IDLE;
            endcase

            if (final_hs) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end

            // BRAM return stage: write the FIFO unless the word goes straight to the serializer.
            if (fifo_wr)   wr_ptr <= wr_ptr + 1'b1;
            if (load_fifo) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(load_fifo);

            // Serializer stage: reload on the lane-3 handshake so a non-empty FIFO never bubbles.
            if (load_fifo | load_bypass) begin
                hold_vld   <= 1'b1;
                lane       <= '0;
                hold_final <= (pop_left == 1);
                pop_left   <= pop_left - 1'b1;
            end else if (hs) begin
                if (at_last_lane) begin
                    hold_vld <= 1'b0;
                    lane     <= '0;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_62clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= bus.i_q;
        if (load_fifo)        hold_word <= fifo_mem[rd_ptr];
        else if (load_bypass) hold_word <= bus.i_q;
    end

    assign bus.o_rdaddress = rdaddress;
    assign bus.o_rden      = rden;
    assign bus.o_sample    = hold_vld ? hold_word[lane*SAMPLE_W +: SAMPLE_W] : '0;
    assign bus.o_valid     = hold_vld;
    assign bus.o_last      = hold_vld & at_last_lane & hold_final;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
endmodule

// File: tb/tb_bram_sample_reader.sv
// Bench for bram_sample_reader: BRAM model, per-cycle observer and a word-list reference model.
module tb_bram_sample_reader;
    localparam int ADDR_W = 14, DATA_W = 64, SAMPLE_W = 16, RD_LAT = 2, FIFO_DEPTH = 4;
    localparam int NWORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_sample_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W)) bus();

    bram_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W),
                         .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_62clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    logic [DATA_W-1:0] mem [NWORDS];
    logic [DATA_W-1:0] rd_p1;
    always @(posedge clk) begin
        if (bus.o_rden) rd_p1 <= mem[bus.o_rdaddress];
        bus.i_q <= rd_p1;
    end

    int total = 0;
    int bad = 0;
    int cyc, first_valid_cyc, done_cyc, last_hs_cyc, done_cnt, rden_cnt, hs_cnt;
    int stall_viol, max_out, busy_seen, valid_seen, done_busy, pct;
    logic c1_busy, c1_rden;
    logic [ADDR_W-1:0] c1_addr;
    logic prev_stall, prev_last;
    logic [SAMPLE_W-1:0] prev_sample;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    int addr_q[$];

    task automatic clear_obs();
        cyc = 0; first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
        done_cnt = 0; rden_cnt = 0; hs_cnt = 0; stall_viol = 0; max_out = 0;
        busy_seen = 0; valid_seen = 0; done_busy = 0; prev_stall = 1'b0;
        got_q.delete(); exp_q.delete(); addr_q.delete();
    endtask

    // One clock of observation; inputs for the next edge are driven at the falling edge.
    task automatic step();
        logic rdy;
        @(negedge clk);
        cyc++;
        bus.i_start = 1'b0;
        if (cyc == 1) begin
            c1_busy = bus.o_busy; c1_rden = bus.o_rden; c1_addr = bus.o_rdaddress;
        end
        if (prev_stall && !(bus.o_valid && bus.o_sample == prev_sample && bus.o_last == prev_last))
            stall_viol++;
        if (bus.o_rden) begin rden_cnt++; addr_q.push_back(int'(bus.o_rdaddress)); end
        if (rden_cnt - hs_cnt / 4 > max_out) max_out = rden_cnt - hs_cnt / 4;
        if (bus.o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            if (bus.o_busy) done_busy++;
        end
        if (bus.o_busy) busy_seen++;
        if (bus.o_valid) begin
            valid_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        rdy = (int'($urandom_range(0, 99)) < pct);
        if (bus.o_valid && rdy) begin
            got_q.push_back({bus.o_last, bus.o_sample});
            hs_cnt++;
            last_hs_cyc = cyc;
        end
        prev_stall  = bus.o_valid && !rdy;
        prev_sample = bus.o_sample;
        prev_last   = bus.o_last;
        bus.i_ready = rdy;
    endtask

    task automatic start_xfer(input int base, input int count);
        clear_obs();
        bus.i_start      = 1'b1;
        bus.i_base_addr  = ADDR_W'(base);
        bus.i_word_count = (ADDR_W+1)'(count);
        bus.i_ready      = (int'($urandom_range(0, 99)) < pct);
    endtask

    task automatic run_until_done(input int budget, output bit timed_out);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step(); n++; end
        timed_out = (done_cnt == 0);
        repeat (3) step();
    endtask

    // Reference: words in address order (wrapping), lanes low to high, last flag on the final lane.
    task automatic add_words(input int base, input int count);
        for (int w = 0; w < count; w++) begin
            logic [DATA_W-1:0] word;
            word = mem[(base + w) % NWORDS];
            for (int l = 0; l < 4; l++)
                exp_q.push_back({(w == count - 1 && l == 3), word[l*16 +: 16]});
        end
    endtask

    task automatic fill_random(input int base, input int count);
        for (int w = 0; w < count; w++) mem[(base + w) % NWORDS] = {$urandom, $urandom};
    endtask

    function automatic int first_diff();
        int n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_word_count = '0;
        bus.i_ready = 1'b0; pct = 0; clear_obs();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.o_rden, bus.o_valid, bus.o_last, bus.o_busy, bus.o_done} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000",
                {bus.o_rden, bus.o_valid, bus.o_last, bus.o_busy, bus.o_done});
        end
        total++;
        if (bus.o_rdaddress !== '0) begin
            bad++; $display("FAIL reset_addr: got %0d want 0", bus.o_rdaddress);
        end
        total++;
        if (bus.o_sample !== '0) begin
            bad++; $display("FAIL reset_sample: got %h want 0", bus.o_sample);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_word();
        bit to;
        int d;
        mem[0] = 64'h0004_0003_0002_0001;
        pct = 100;
        start_xfer(0, 1);
        add_words(0, 1);
        run_until_done(40, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout: got no done want done"); end
        total++;
        if ({c1_busy, c1_rden} !== 2'b11 || c1_addr !== '0) begin
            bad++; $display("FAIL single_cycle1: got busy=%b rden=%b addr=%0d want 1 1 0",
                c1_busy, c1_rden, c1_addr);
        end
        total++;
        if (first_valid_cyc !== 2 + RD_LAT) begin
            bad++; $display("FAIL single_latency: got %0d want %0d", first_valid_cyc, 2 + RD_LAT);
        end
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL single_samples: index %0d got %0d samples want %0d", d, got_q.size(), exp_q.size());
        end
        total++;
        if (last_hs_cyc !== first_valid_cyc + 3) begin
            bad++; $display("FAIL single_no_bubble: got last hs cycle %0d want %0d", last_hs_cyc, first_valid_cyc + 3);
        end
        total++;
        if (done_cyc !== last_hs_cyc + 1) begin
            bad++; $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, last_hs_cyc + 1);
        end
        total++;
        if (done_busy !== 0) begin bad++; $display("FAIL single_busy_at_done: got %0d want 0", done_busy); end
        total++;
        if (rden_cnt !== 1) begin bad++; $display("FAIL single_rden_count: got %0d want 1", rden_cnt); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit to;
        bit addr_ok;
        int exp_a[4] = '{16382, 16383, 0, 1};
        int d;
        fill_random(16382, 4);
        pct = 100;
        start_xfer(16382, 4);
        add_words(16382, 4);
        run_until_done(80, to);
        total++; if (to) begin bad++; $display("FAIL wrap_timeout: got no done want done"); end
        addr_ok = (addr_q.size() == 4);
        for (int i = 0; i < 4 && addr_ok; i++) if (addr_q[i] != exp_a[i]) addr_ok = 1'b0;
        total++;
        if (!addr_ok) begin
            bad++; $display("FAIL wrap_addr: got %0d reads first %0d want 16382,16383,0,1",
                addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1);
        end
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL wrap_samples: index %0d got %0d samples want %0d", d, got_q.size(), exp_q.size());
        end
        total++;
        if (last_hs_cyc - first_valid_cyc !== 15) begin
            bad++; $display("FAIL wrap_no_bubble: got span %0d want 15", last_hs_cyc - first_valid_cyc);
        end
    endtask

    task automatic test_random_ready();
        bit to;
        int base, d;
        base = int'($urandom_range(0, NWORDS - 1));
        fill_random(base, 64);
        pct = 30;
        start_xfer(base, 64);
        add_words(base, 64);
        run_until_done(4000, to);
        total++; if (to) begin bad++; $display("FAIL rand_timeout: got no done want done"); end
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL rand_samples: index %0d got %0d samples want %0d", d, got_q.size(), exp_q.size());
        end
        total++;
        if (stall_viol !== 0) begin bad++; $display("FAIL rand_stable: got %0d changes want 0", stall_viol); end
        total++;
        if (max_out > FIFO_DEPTH) begin
            bad++; $display("FAIL rand_outstanding: got %0d want <= %0d", max_out, FIFO_DEPTH);
        end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL rand_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        bit to;
        int base, d;
        base = int'($urandom_range(0, NWORDS - 1));
        fill_random(base, 16);
        pct = 0;
        start_xfer(base, 16);
        add_words(base, 16);
        repeat (100) step();
        total++;
        if (rden_cnt !== FIFO_DEPTH) begin
            bad++; $display("FAIL stall_rden_count: got %0d want %0d", rden_cnt, FIFO_DEPTH);
        end
        total++;
        if (first_valid_cyc !== 2 + RD_LAT || bus.o_valid !== 1'b1) begin
            bad++; $display("FAIL stall_valid: got first %0d now %b want %0d 1", first_valid_cyc, bus.o_valid, 2 + RD_LAT);
        end
        total++;
        if (stall_viol !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
        pct = 100;
        run_until_done(300, to);
        total++; if (to) begin bad++; $display("FAIL stall_timeout: got no done want done"); end
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL stall_samples: index %0d got %0d samples want %0d", d, got_q.size(), exp_q.size());
        end
        total++;
        if (max_out > FIFO_DEPTH) begin
            bad++; $display("FAIL stall_outstanding: got %0d want <= %0d", max_out, FIFO_DEPTH);
        end
    endtask

    task automatic test_zero_count();
        pct = 100;
        start_xfer(5, 0);
        repeat (6) step();
        total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        total++; if (rden_cnt !== 0) begin bad++; $display("FAIL zero_rden: got %0d want 0", rden_cnt); end
        total++; if (busy_seen !== 0) begin bad++; $display("FAIL zero_busy: got %0d want 0", busy_seen); end
        total++; if (valid_seen !== 0) begin bad++; $display("FAIL zero_valid: got %0d want 0", valid_seen); end
    endtask

    task automatic test_reset_abort();
        bit to;
        bit addr_ok;
        int base, n, d;
        base = int'($urandom_range(0, NWORDS - 1));
        fill_random(base, 16);
        pct = 100;
        start_xfer(base, 16);
        n = 0;
        while (got_q.size() < 20 && n < 200) begin step(); n++; end
        total++;
        if (got_q.size() < 20) begin bad++; $display("FAIL abort_progress: got %0d samples want 20", got_q.size()); end
        rst = 1'b1;
        step();
        total++;
        if ({bus.o_busy, bus.o_valid, bus.o_rden, bus.o_done} !== 4'b0) begin
            bad++; $display("FAIL abort_idle: got %b want 0000", {bus.o_busy, bus.o_valid, bus.o_rden, bus.o_done});
        end
        rst = 1'b0;
        repeat (5) step();
        total++;
        if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        fill_random(100, 2);
        start_xfer(100, 2);
        add_words(100, 2);
        repeat (3) step();
        bus.i_start = 1'b1; bus.i_base_addr = ADDR_W'(200); bus.i_word_count = (ADDR_W+1)'(5);
        run_until_done(100, to);
        total++; if (to) begin bad++; $display("FAIL abort_timeout: got no done want done"); end
        addr_ok = (addr_q.size() == 2) && (addr_q[0] == 100) && (addr_q[1] == 101);
        total++;
        if (!addr_ok) begin bad++; $display("FAIL abort_addr: got %0d reads want 100,101", addr_q.size()); end
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL abort_samples: index %0d got %0d samples want %0d", d, got_q.size(), exp_q.size());
        end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_wrap();
        test_random_ready();
        test_stall();
        test_zero_count();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
